// File: rtl/instr_fetch_pkg.sv
// Shared cpu definitions: default widths, instruction-type codes and fetch-FSM encodings.
// Users of this package pick up the end-of-memory policy from macro IFU_LOOP_EN in instr_fetch.
package instr_fetch_pkg;

  localparam int CPU_ADDR_BITS   = 5;
  localparam int CPU_INSTR_WIDTH = 20;

  // The two MSBs of every instruction word carry its type.
  typedef enum logic [1:0] {
    ITYPE_HALT    = 2'b00,
    ITYPE_STD_OP  = 2'b01,
    ITYPE_LOAD_R  = 2'b10,
    ITYPE_STORE_R = 2'b11
  } itype_e;

  localparam logic [1:0] IFU_IDLE    = 2'd0;
  localparam logic [1:0] IFU_FETCH   = 2'd1;
  localparam logic [1:0] IFU_PRESENT = 2'd2;
  localparam logic [1:0] IFU_HALT    = 2'd3;

  function automatic logic is_halt(input logic [1:0] type_code);
    return itype_e'(type_code) == ITYPE_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Instruction storage: 2^ADDR_BITS x INSTR_WIDTH register array,
// synchronous write port and combinational read port.
module instr_mem #(
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset on purpose; the program must survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program memory one word per 'next', stopping on a halt word.
// Define IFU_LOOP_EN to wrap from the last address back to 0 instead of halting there.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_BITS   = CPU_ADDR_BITS,
  parameter int INSTR_WIDTH = CPU_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   next,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   instr_valid,
  output logic                   halted
);

  localparam logic [ADDR_BITS-1:0] PC_LAST = '1;

  logic [1:0]             state;
  logic [INSTR_WIDTH-1:0] rd_word;
  logic                   mem_we;

  // Programming is only allowed while nothing is executing; rst blocks it too.
  assign mem_we = prog_we && !rst && (state == IFU_IDLE || state == IFU_HALT);

  instr_mem #(
    .ADDR_BITS   (ADDR_BITS),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IFU_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: begin
          if (start) state <= IFU_FETCH;
        end
        IFU_FETCH: begin
          if (is_halt(rd_word[INSTR_WIDTH-1 -: 2])) begin
            state       <= IFU_HALT;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            state       <= IFU_PRESENT;
            instr       <= rd_word;
            instr_valid <= 1'b1;
          end
        end
        IFU_PRESENT: begin
          if (next) begin
            if (pc != PC_LAST) begin
              pc          <= pc + 1'b1;
              instr_valid <= 1'b0;
              state       <= IFU_FETCH;
            end else begin
`ifdef IFU_LOOP_EN
              pc          <= '0;
              instr_valid <= 1'b0;
              state       <= IFU_FETCH;
`else
              state       <= IFU_HALT;
              instr       <= '0;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
`endif
            end
          end
        end
        IFU_HALT: begin
          if (start) begin
            state  <= IFU_FETCH;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_instr_fetch;

  localparam int AW   = 5;
  localparam int IW   = 20;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          next = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;
  logic          instr_valid;
  logic          halted;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch #(.ADDR_BITS(AW), .INSTR_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .next        (next),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: program image plus what the consumer should currently see.
  typedef enum {M_IDLE, M_FETCH, M_SHOW, M_STOP} phase_e;
  phase_e        m_phase = M_IDLE;
  logic [IW-1:0] m_mem [NW];
  int            m_pc = 0;
  logic [IW-1:0] m_instr = '0;
  bit            m_valid = 0;
  bit            m_halted = 0;
  bit            model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE; m_pc = 0; m_instr = '0; m_valid = 0; m_halted = 0;
      model_live = 1;
    end else if (model_live) begin
      case (m_phase)
        M_IDLE, M_STOP: begin
          if (prog_we) m_mem[prog_addr] = prog_data;
          if (start) begin
            m_phase = M_FETCH; m_pc = 0; m_halted = 0;
          end
        end
        M_FETCH: begin
          if (m_mem[m_pc][19:18] == 2'b00) begin
            m_phase = M_STOP; m_instr = '0; m_valid = 0; m_halted = 1;
          end else begin
            m_phase = M_SHOW; m_instr = m_mem[m_pc]; m_valid = 1;
          end
        end
        M_SHOW: begin
          if (next) begin
            if (m_pc < NW - 1) begin
              m_pc = m_pc + 1; m_valid = 0; m_phase = M_FETCH;
            end else begin
`ifdef IFU_LOOP_EN
              m_pc = 0; m_valid = 0; m_phase = M_FETCH;
`else
              m_phase = M_STOP; m_halted = 1; m_valid = 0; m_instr = '0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("instr", 32'(instr), 32'(m_instr));
      check("pc", 32'(pc), 32'(m_pc));
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [IW-1:0] data);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid) return;
      tick();
    end
    if (!instr_valid) check("wait_valid timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic step_next();
    next = 1'b1;
    tick();
    next = 1'b0;
    wait_valid(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] w;
    tick();
    tick();
    rst = 1'b0;
    check("reset pc", 32'(pc), 32'd0);
    check("reset instr", 32'(instr), 32'd0);
    check("reset valid", 32'(instr_valid), 32'd0);
    check("reset halted", 32'(halted), 32'd0);

    // Basic program ending in a halt word.
    write_word(0, 20'h4_1230);
    write_word(1, 20'h8_2010);
    write_word(2, 20'h0_0000);
    pulse_start();
    check("first instr", 32'(instr), 32'h41230);
    check("first pc", 32'(pc), 32'd0);
    check("first valid", 32'(instr_valid), 32'd1);
    step_next();
    check("second instr", 32'(instr), 32'h82010);
    check("second pc", 32'(pc), 32'd1);
    next = 1'b1; tick(); next = 1'b0; tick();
    check("halt word halted", 32'(halted), 32'd1);
    check("halt word instr", 32'(instr), 32'd0);

    // Reprogram while halted, then hold PRESENT and try a forbidden write.
    write_word(2, 20'h4_0002);
    write_word(3, 20'hC_0003);
    write_word(4, 20'h4_0004);
    write_word(5, 20'h8_0005);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold instr", 32'(instr), 32'h41230);
      check("hold pc", 32'(pc), 32'd0);
      check("hold valid", 32'(instr_valid), 32'd1);
    end
    write_word(3, 20'h0_0000);
    step_next();
    step_next();
    step_next();
    check("mem3 kept", 32'(instr), 32'hC0003);
    check("mem3 pc", 32'(pc), 32'd3);
    step_next();
    step_next();
    check("pc before rst", 32'(pc), 32'd5);

    // Reset mid-program, then restart from the intact image.
    do_reset();
    check("rst pc", 32'(pc), 32'd0);
    check("rst instr", 32'(instr), 32'd0);
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    pulse_start();
    check("restart instr", 32'(instr), 32'h41230);

    // start together with a write to address 0.
    do_reset();
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 20'h4_5670;
    tick();
    start = 1'b0; prog_we = 1'b0;
    tick();
    check("start+write instr", 32'(instr), 32'h45670);
    check("start+write valid", 32'(instr_valid), 32'd1);

    // End of memory.
    do_reset();
    for (int a = 0; a < NW; a++) write_word(a, 20'h4_0001);
    pulse_start();
    for (int k = 1; k < NW; k++) step_next();
    check("last pc", 32'(pc), 32'(NW - 1));
    next = 1'b1; tick(); next = 1'b0;
`ifdef IFU_LOOP_EN
    wait_valid(4);
    check("wrap pc", 32'(pc), 32'd0);
    check("wrap valid", 32'(instr_valid), 32'd1);
`else
    check("eom halted", 32'(halted), 32'd1);
    check("eom instr", 32'(instr), 32'd0);
    check("eom valid", 32'(instr_valid), 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int a = 0; a < NW; a++) begin
      w = IW'($urandom);
      if ($urandom_range(0, 5) == 0) w[19:18] = 2'b00;
      write_word(a, w);
    end
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 15) == 0);
      next      = ($urandom_range(0, 2) == 0);
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = AW'($urandom);
      w = IW'($urandom);
      if ($urandom_range(0, 5) == 0) w[19:18] = 2'b00;
      prog_data = w;
      tick();
    end
    rst = 1'b0; start = 1'b0; next = 1'b0; prog_we = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 5, instruction-memory address width (32 words).
REQ-002 SHALL have parameter INSTR_WIDTH, default 20, instruction word width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin or restart execution from address 0.
REQ-006 SHALL have port next  input  1  consumer has finished the current instruction; advance.
REQ-007 SHALL have port prog_we  input  1  instruction-memory write enable.
REQ-008 SHALL have port prog_addr  input  ADDR_BITS  write address.
REQ-009 SHALL have port prog_data  input  INSTR_WIDTH  write data.
REQ-010 SHALL have port instr  output  INSTR_WIDTH  registered instruction presented to the control unit.
REQ-011 SHALL have port pc  output  ADDR_BITS  address of the instruction in instr.
REQ-012 SHALL have port instr_valid  output  1  instr holds a live instruction.
REQ-013 SHALL have port halted  output  1  execution stopped at a halt word or at the end of memory.

Function
REQ-014 SHALL implement states IDLE, FETCH, PRESENT and HALT.
REQ-015 SHALL perform a prog_we write at the clock edge only in IDLE or HALT; prog_we in any other state SHALL be ignored.
REQ-016 SHALL move IDLE->FETCH, or HALT->FETCH with pc<=0 and halted<=0, when start=1; start in FETCH or PRESENT SHALL be ignored.
REQ-017 In FETCH, if mem[pc][19:18]==2'b00 (halt word) the block SHALL go to HALT with instr<=0, instr_valid<=0 and halted<=1.
REQ-018 In FETCH with a non-halt word, the block SHALL set instr<=mem[pc] and instr_valid<=1, and go to PRESENT; instr_valid rises 2 cycles after start is sampled.
REQ-019 In PRESENT, instr and pc SHALL stay stable until next=1 is sampled.
REQ-020 On next=1 in PRESENT with pc<2^ADDR_BITS-1, the block SHALL set pc<=pc+1 and instr_valid<=0, and go to FETCH; instr SHALL keep its old value until replaced.
REQ-021 On next=1 in PRESENT with pc==2^ADDR_BITS-1, end-of-memory behaviour SHALL follow REQ-029/REQ-030.
REQ-022 next outside PRESENT SHALL be ignored.
REQ-023 start and prog_we asserted together in IDLE SHALL both take effect; the following FETCH SHALL see the newly written word if prog_addr==0.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL enter IDLE with pc=0, instr=0, instr_valid=0 and halted=0, regardless of the current state.
REQ-025 rst SHALL take priority over start, next and prog_we in the same cycle.
REQ-026 Reset SHALL NOT clear instruction-memory contents.
REQ-027 instr=0 while idle or halted SHALL hold the downstream control unit in its reset state.

Configuration
REQ-028 Macro IFU_LOOP_EN SHALL select the end-of-memory behaviour.
REQ-029 With IFU_LOOP_EN defined, next=1 at pc==2^ADDR_BITS-1 SHALL wrap pc to 0 and go to FETCH.
REQ-030 Without IFU_LOOP_EN, next=1 at pc==2^ADDR_BITS-1 SHALL go to HALT with halted<=1, instr_valid<=0 and instr<=0.

Structure
REQ-031 A shared cpu package SHALL hold ADDR_BITS, INSTR_WIDTH, the instruction-type codes (00 halt, 01 std_op, 10 loadR, 11 storeR) and the fetch state encodings.
REQ-032 Storage SHALL be a sub-module instr_mem: 2^ADDR_BITS x INSTR_WIDTH register array, synchronous write, combinational read.

Verification
REQ-033 Program mem[0]=20'h4_1230, mem[1]=20'h8_2010, mem[2]=0, then pulse start -> instr=20'h41230 and pc=0 with instr_valid=1 two cycles after start; next -> pc=1 and instr=20'h82010; next -> halted=1, instr=0.
REQ-034 Hold next=0 for 10 cycles in PRESENT -> instr and pc stay unchanged and instr_valid stays 1.
REQ-035 Assert prog_we with addr 3 while in PRESENT -> mem[3] unchanged, as confirmed by a later fetch of address 3.
REQ-036 Fill all 32 words with 20'h4_0001 and issue 32 next pulses -> with IFU_LOOP_EN, pc returns to 0 and instr_valid=1; without it, halted=1 and instr=0.
REQ-037 Assert rst during PRESENT at pc=5 -> the next cycle shows IDLE, pc=0, instr=0, instr_valid=0, and memory contents are intact on restart.
REQ-038 Assert start and prog_we (addr 0, data 20'h4_5670) in the same IDLE cycle -> the first presented instr is 20'h45670.
